sram_like_responder: RTL and testbench

- Slave (responder) end of the sram-like interface that the fetch and memory stages drive (req / addr_ok / data_ok).
- Accepts requests from one master and drives a synchronous single-port RAM with 1-cycle read latency.
- Supports up to DEPTH outstanding transactions, returned strictly in order.
- Programmable addr_ok / data_ok delays so the bench can stress the CPU pipeline's handshake and cancel logic.

---
 rtl/sram_like_responder_pkg.sv | 11 +
 rtl/sram_like_responder_fifo.sv | 50 +++++
 rtl/sram_like_responder.sv | 126 ++++++++++++
 tb/tb_sram_like_responder.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_responder_pkg.sv
// Shared constants for the sram-like responder: transfer size encodings and
// the width of one queued response ({is_write, data}).
package sram_like_responder_pkg;

    localparam logic [1:0] SRAM_SIZE_B = 2'd0;
    localparam logic [1:0] SRAM_SIZE_H = 2'd1;
    localparam logic [1:0] SRAM_SIZE_W = 2'd2;

    localparam int RESP_W = 33;

endpackage

// File: rtl/sram_like_responder_fifo.sv
// In-order response queue: DEPTH entries of WIDTH bits, circular pointers,
// combinational head. DEPTH must be a power of 2 so the pointers wrap naturally.
module resp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    // Storage carries no reset so it maps onto plain distributed RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/sram_like_responder.sv
// Slave end of the sram-like req/addr_ok/data_ok interface in front of a
// 1-cycle-latency synchronous RAM, with tunable accept and response delays.
module sram_like_responder
    import sram_like_responder_pkg::*;
#(
    parameter int RAM_AW     = 16,
    parameter int DEPTH      = 2,
    parameter int ADDR_DELAY = 0,
    parameter int DATA_DELAY = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [3:0]        wstrb,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [31:0]       rdata,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int OW  = $clog2(DEPTH + 1);
    localparam int ACW = (ADDR_DELAY > 0) ? $clog2(ADDR_DELAY + 1) : 1;
    localparam int DCW = (DATA_DELAY > 0) ? $clog2(DATA_DELAY + 1) : 1;

    logic [OW-1:0]     outstanding_reg;
    logic [ACW-1:0]    acnt_reg;
    logic [DCW-1:0]    dcnt_reg;
    logic              pipe_valid_reg;
    logic              pipe_wr_reg;

    logic              handshake;
    logic              addr_wait_done;
    logic              head_valid;
    logic              head_ready;
    logic              bypass;
    logic              fifo_push;
    logic              fifo_pop;
    logic [OW-1:0]     fifo_count;
    logic [RESP_W-1:0] head_data;
    logic [RESP_W-1:0] pipe_resp;
    logic              unused_bits;

    // Accept side: a response leaving this cycle does not free a slot until next cycle.
    assign addr_wait_done = (int'(acnt_reg) >= ADDR_DELAY);
    assign addr_ok        = resetn && req && (int'(outstanding_reg) < DEPTH) && addr_wait_done;
    assign handshake      = addr_ok;

    assign ram_en    = handshake;
    assign ram_addr  = addr[RAM_AW+1:2];
    assign ram_wdata = wdata;

    for (genvar gi = 0; gi < 4; gi++) begin : g_wen
        assign ram_wen[gi] = handshake & wr & wstrb[gi];
    end

    // Writes answer with zero data; reads pick up the RAM word one cycle later.
    assign pipe_resp  = {pipe_wr_reg, (pipe_wr_reg ? 32'd0 : ram_rdata)};

    assign head_valid = (fifo_count != '0);
    assign head_ready = head_valid && (int'(dcnt_reg) == DATA_DELAY);
    assign bypass     = (DATA_DELAY == 0) && !head_valid && pipe_valid_reg;

    assign data_ok    = resetn && (head_ready || bypass);
    assign fifo_pop   = resetn && head_ready;
    assign fifo_push  = pipe_valid_reg && !bypass;

    always_comb begin
        rdata = 32'd0;
        if (data_ok) begin
            rdata = head_ready ? head_data[31:0] : pipe_resp[31:0];
        end
    end

    resp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RESP_W)
    ) u_resp_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (fifo_push),
        .push_data (pipe_resp),
        .pop       (fifo_pop),
        .head_data (head_data),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            outstanding_reg <= '0;
            acnt_reg        <= '0;
            dcnt_reg        <= '0;
            pipe_valid_reg  <= 1'b0;
            pipe_wr_reg     <= 1'b0;
        end else begin
            outstanding_reg <= outstanding_reg + OW'(handshake) - OW'(data_ok);

            if (!req || handshake) begin
                acnt_reg <= '0;
            end else if (int'(acnt_reg) < ADDR_DELAY) begin
                acnt_reg <= acnt_reg + ACW'(1);
            end

            // The head wait restarts whenever a new entry becomes head.
            if (!head_valid || fifo_pop) begin
                dcnt_reg <= '0;
            end else if (int'(dcnt_reg) < DATA_DELAY) begin
                dcnt_reg <= dcnt_reg + DCW'(1);
            end

            pipe_valid_reg <= handshake;
            pipe_wr_reg    <= handshake & wr;
        end
    end

    assign unused_bits = ^{size, addr[1:0], addr[31:RAM_AW+2], head_data[RESP_W-1]}
                         ^ (size > SRAM_SIZE_W);

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench: three responder instances (plain, DATA_DELAY=3, ADDR_DELAY=2)
// share one stimulus bus, each backed by its own behavioural RAM.
module tb_sram_like_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        addr_ok   [3];
    logic        data_ok   [3];
    logic [31:0] rdata     [3];
    logic        ram_en    [3];
    logic [3:0]  ram_wen   [3];
    logic [7:0]  ram_addr  [3];
    logic [31:0] ram_wdata [3];

    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;

    logic [31:0] b2b [4];
    int          checks;
    int          errors;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        logic [31:0] mem [256];
        logic [31:0] rd_q;

        sram_like_responder #(
            .RAM_AW     (8),
            .DEPTH      (2),
            .ADDR_DELAY ((gi == 2) ? 2 : 0),
            .DATA_DELAY ((gi == 1) ? 3 : 0)
        ) u_dut (
            .clk       (clk),
            .resetn    (resetn),
            .req       (req),
            .wr        (wr),
            .size      (size),
            .wstrb     (wstrb),
            .addr      (addr),
            .wdata     (wdata),
            .addr_ok   (addr_ok[gi]),
            .data_ok   (data_ok[gi]),
            .rdata     (rdata[gi]),
            .ram_en    (ram_en[gi]),
            .ram_wen   (ram_wen[gi]),
            .ram_addr  (ram_addr[gi]),
            .ram_wdata (ram_wdata[gi]),
            .ram_rdata (rd_q)
        );

        always @(posedge clk) begin
            if (pl_en) begin
                mem[pl_addr] <= pl_data;
            end else if (ram_en[gi]) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_wen[gi][b]) mem[ram_addr[gi]][8*b +: 8] <= ram_wdata[gi][8*b +: 8];
                end
                rd_q <= mem[ram_addr[gi]];
            end
        end
    end

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic do_reset();
        req = 1'b0; wr = 1'b0; wstrb = 4'd0; resetn = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (addr_ok[i] !== 1'b0) begin errors++; $display("FAIL reset_addr_ok dut%0d: got %b expected 0", i, addr_ok[i]); end
            checks++;
            if (data_ok[i] !== 1'b0) begin errors++; $display("FAIL reset_data_ok dut%0d: got %b expected 0", i, data_ok[i]); end
            checks++;
            if (rdata[i] !== 32'd0) begin errors++; $display("FAIL reset_rdata dut%0d: got %h expected 0", i, rdata[i]); end
            checks++;
            if (ram_en[i] !== 1'b0) begin errors++; $display("FAIL reset_ram_en dut%0d: got %b expected 0", i, ram_en[i]); end
            checks++;
            if (ram_wen[i] !== 4'd0) begin errors++; $display("FAIL reset_ram_wen dut%0d: got %b expected 0", i, ram_wen[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_read();
        do_reset();
        req = 1'b1; wr = 1'b0; addr = 32'h40;
        @(negedge clk);
        checks++;
        if (addr_ok[0] !== 1'b1) begin errors++; $display("FAIL single_addr_ok: got %b expected 1", addr_ok[0]); end
        checks++;
        if (ram_en[0] !== 1'b1) begin errors++; $display("FAIL single_ram_en: got %b expected 1", ram_en[0]); end
        checks++;
        if (ram_addr[0] !== 8'h10) begin errors++; $display("FAIL single_ram_addr: got %h expected 10", ram_addr[0]); end
        checks++;
        if (data_ok[0] !== 1'b0) begin errors++; $display("FAIL single_early_data_ok: got %b expected 0", data_ok[0]); end
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        $display("xact single_read addr=00000040 data_ok=%b rdata=%h", data_ok[0], rdata[0]);
        checks++;
        if (data_ok[0] !== 1'b1) begin errors++; $display("FAIL single_data_ok: got %b expected 1", data_ok[0]); end
        checks++;
        if (rdata[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata: got %h expected deadbeef", rdata[0]); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (data_ok[0] !== 1'b0) begin errors++; $display("FAIL single_extra_data_ok: got %b expected 0", data_ok[0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int outst;
        int nxt;
        do_reset();
        outst = 0; nxt = 0;
        for (int c = 0; c < 7; c++) begin
            if (c < 4) begin req = 1'b1; wr = 1'b0; addr = 32'(c * 4); end
            else req = 1'b0;
            @(negedge clk);
            if (c < 4) begin
                checks++;
                if (addr_ok[0] !== 1'b1) begin errors++; $display("FAIL b2b_addr_ok c%0d: got %b expected 1", c, addr_ok[0]); end
            end
            checks++;
            if (data_ok[0] !== (c >= 1 && c <= 4)) begin
                errors++; $display("FAIL b2b_data_ok c%0d: got %b expected %b", c, data_ok[0], (c >= 1 && c <= 4));
            end
            if (data_ok[0] === 1'b1 && nxt < 4) begin
                $display("xact b2b read %0d rdata=%h", nxt, rdata[0]);
                checks++;
                if (rdata[0] !== b2b[nxt]) begin errors++; $display("FAIL b2b_rdata %0d: got %h expected %h", nxt, rdata[0], b2b[nxt]); end
                nxt++;
            end
            outst = outst + int'(addr_ok[0]) - int'(data_ok[0]);
            checks++;
            if (outst > 2 || outst < 0) begin errors++; $display("FAIL b2b_outstanding c%0d: got %0d expected 0..2", c, outst); end
            @(posedge clk); #1;
        end
        checks++;
        if (nxt != 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", nxt); end
    endtask

    task automatic test_data_delay();
        int  issued;
        int  got;
        logic exp_aok;
        logic exp_dok;
        do_reset();
        issued = 0; got = 0;
        for (int c = 0; c < 16; c++) begin
            if (issued < 3) begin req = 1'b1; wr = 1'b0; addr = 32'(issued * 4); end
            else req = 1'b0;
            @(negedge clk);
            exp_aok = (c == 0 || c == 1 || c == 6);
            exp_dok = (c == 5 || c == 9 || c == 13);
            checks++;
            if (addr_ok[1] !== exp_aok) begin errors++; $display("FAIL dd_addr_ok c%0d: got %b expected %b", c, addr_ok[1], exp_aok); end
            checks++;
            if (data_ok[1] !== exp_dok) begin errors++; $display("FAIL dd_data_ok c%0d: got %b expected %b", c, data_ok[1], exp_dok); end
            if (data_ok[1] === 1'b1 && got < 4) begin
                $display("xact data_delay read %0d cycle %0d rdata=%h", got, c, rdata[1]);
                checks++;
                if (rdata[1] !== b2b[got]) begin errors++; $display("FAIL dd_rdata %0d: got %h expected %h", got, rdata[1], b2b[got]); end
                got++;
            end
            if (addr_ok[1] === 1'b1) issued++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_write_read();
        do_reset();
        req = 1'b1; wr = 1'b1; wstrb = 4'b0011; addr = 32'h100; wdata = 32'hA5A5A5A5;
        @(negedge clk);
        checks++;
        if (addr_ok[0] !== 1'b1) begin errors++; $display("FAIL wr_addr_ok: got %b expected 1", addr_ok[0]); end
        checks++;
        if (ram_wen[0] !== 4'b0011) begin errors++; $display("FAIL wr_ram_wen: got %b expected 0011", ram_wen[0]); end
        checks++;
        if (ram_addr[0] !== 8'h40) begin errors++; $display("FAIL wr_ram_addr: got %h expected 40", ram_addr[0]); end
        checks++;
        if (ram_wdata[0] !== 32'hA5A5A5A5) begin errors++; $display("FAIL wr_ram_wdata: got %h expected a5a5a5a5", ram_wdata[0]); end
        @(posedge clk); #1;
        wr = 1'b0; wstrb = 4'd0;
        @(negedge clk);
        $display("xact write addr=00000100 data_ok=%b rdata=%h", data_ok[0], rdata[0]);
        checks++;
        if (addr_ok[0] !== 1'b1) begin errors++; $display("FAIL rd_addr_ok: got %b expected 1", addr_ok[0]); end
        checks++;
        if (ram_wen[0] !== 4'd0) begin errors++; $display("FAIL rd_ram_wen: got %b expected 0000", ram_wen[0]); end
        checks++;
        if (data_ok[0] !== 1'b1 || rdata[0] !== 32'd0) begin
            errors++; $display("FAIL wr_resp: got data_ok=%b rdata=%h expected 1/00000000", data_ok[0], rdata[0]);
        end
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        $display("xact read addr=00000100 data_ok=%b rdata=%h", data_ok[0], rdata[0]);
        checks++;
        if (data_ok[0] !== 1'b1 || rdata[0] !== 32'h1234A5A5) begin
            errors++; $display("FAIL rd_after_wr: got data_ok=%b rdata=%h expected 1/1234a5a5", data_ok[0], rdata[0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_addr_delay();
        do_reset();
        wr = 1'b0; addr = 32'h20;
        for (int c = 0; c < 5; c++) begin
            req = (c != 1);
            @(negedge clk);
            checks++;
            if (addr_ok[2] !== (c == 4)) begin errors++; $display("FAIL ad_addr_ok c%0d: got %b expected %b", c, addr_ok[2], (c == 4)); end
            checks++;
            if (ram_en[2] !== (c == 4)) begin errors++; $display("FAIL ad_ram_en c%0d: got %b expected %b", c, ram_en[2], (c == 4)); end
            if (c == 4) begin
                checks++;
                if (ram_addr[2] !== 8'h08) begin errors++; $display("FAIL ad_ram_addr: got %h expected 08", ram_addr[2]); end
            end
            @(posedge clk); #1;
        end
        req = 1'b0;
        @(negedge clk);
        $display("xact addr_delay read addr=00000020 data_ok=%b rdata=%h", data_ok[2], rdata[2]);
        checks++;
        if (data_ok[2] !== 1'b1 || rdata[2] !== 32'h20202020) begin
            errors++; $display("FAIL ad_resp: got data_ok=%b rdata=%h expected 1/20202020", data_ok[2], rdata[2]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_inflight();
        do_reset();
        wr = 1'b0;
        for (int c = 0; c < 2; c++) begin
            req = 1'b1; addr = 32'(c * 4);
            @(negedge clk);
            checks++;
            if (addr_ok[1] !== 1'b1) begin errors++; $display("FAIL rif_issue_addr_ok c%0d: got %b expected 1", c, addr_ok[1]); end
            @(posedge clk); #1;
        end
        req = 1'b0; resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (addr_ok[1] !== 1'b0 || data_ok[1] !== 1'b0 || ram_en[1] !== 1'b0 || ram_wen[1] !== 4'd0) begin
            errors++;
            $display("FAIL rif_after_reset: got addr_ok=%b data_ok=%b ram_en=%b ram_wen=%b expected all 0",
                     addr_ok[1], data_ok[1], ram_en[1], ram_wen[1]);
        end
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (data_ok[1] !== 1'b0) begin errors++; $display("FAIL rif_stale_data_ok c%0d: got %b expected 0", c, data_ok[1]); end
        end
        @(posedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            req = 1'b1; addr = 32'h8;
            @(negedge clk);
            checks++;
            if (addr_ok[1] !== 1'b1) begin errors++; $display("FAIL rif_slots_free c%0d: got %b expected 1", c, addr_ok[1]); end
            @(posedge clk); #1;
        end
        req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0; errors = 0;
        resetn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd2; wstrb = 4'd0;
        addr = 32'd0; wdata = 32'd0;
        pl_en = 1'b0; pl_addr = 8'd0; pl_data = 32'd0;
        b2b = '{32'h11110000, 32'h22221111, 32'h33332222, 32'h44443333};
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) preload(8'(i), b2b[i]);
        preload(8'h08, 32'h20202020);
        preload(8'h10, 32'hDEADBEEF);
        preload(8'h40, 32'h12345678);

        test_reset();
        test_single_read();
        test_back_to_back();
        test_data_delay();
        test_write_read();
        test_addr_delay();
        test_reset_inflight();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
